// File: rtl/split_32o_pkg.sv
// Shared stream constants and helpers for the channel split/merge datapath.
`default_nettype none

package split_32o_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CH         = 32;
  localparam int DEF_D          = 110;

  // Counter width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bit offset of lane k in a packed CH*dw bus.
  function automatic int lane_lo(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/split_32o_if.sv
// Serial-in / parallel-out stream bundle for the channel split stage.
`default_nettype none

interface split_32o_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CH         = 32
);

  logic                       valid_in;
  logic                       sof_in;
  logic [DATA_WIDTH-1:0]      pxl_in;
  logic [CH*DATA_WIDTH-1:0]   pxl_out;
  logic                       valid_out;
  logic                       frame_done;
  logic                       align_err;

  modport master (
    output valid_in, sof_in, pxl_in,
    input  pxl_out, valid_out, frame_done, align_err
  );

  modport slave (
    input  valid_in, sof_in, pxl_in,
    output pxl_out, valid_out, frame_done, align_err
  );

endinterface

`default_nettype wire

// File: rtl/split_32o_pos_counter.sv
// Channel/pixel position tracking, sof realignment and emit/frame strobes.
`default_nettype none

module split_pos_counter
  import split_32o_pkg::*;
#(
  parameter int D    = DEF_D,
  parameter int CH   = DEF_CH,
  parameter int CH_W = idx_width(CH)
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            i_valid,
  input  wire logic            i_sof,
  output logic                 o_wr_en,
  output logic [CH_W-1:0]      o_wr_idx,
  output logic                 o_emit,
  output logic                 o_valid_out,
  output logic                 o_frame_done,
  output logic                 o_align_err
);

  localparam int PIX_W = idx_width(D * D);

  logic [CH_W-1:0]  r_ch_cnt;
  logic [PIX_W-1:0] r_pix_cnt;
  logic             r_valid_out;
  logic             r_frame_done;
  logic             r_align_err;

  logic w_last;
  logic w_pix_last;
  logic w_emit;

  assign w_last     = (r_ch_cnt == CH_W'(CH - 1));
  assign w_pix_last = (r_pix_cnt == PIX_W'(D * D - 1));
  // sof outranks the last-channel slot: the word restarts a group instead.
  assign w_emit     = i_valid & ~i_sof & w_last;

  assign o_wr_en  = i_valid & (i_sof | ~w_last);
  assign o_wr_idx = i_sof ? '0 : r_ch_cnt;
  assign o_emit   = w_emit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ch_cnt     <= '0;
      r_pix_cnt    <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      r_align_err  <= 1'b0;
    end else begin
      r_valid_out  <= w_emit;
      r_frame_done <= w_emit & w_pix_last;
      if (i_valid) begin
        if (i_sof) begin
          r_ch_cnt  <= CH_W'(1);
          r_pix_cnt <= '0;
          if ((r_ch_cnt != '0) || (r_pix_cnt != '0))
            r_align_err <= 1'b1;
        end else if (w_last) begin
          r_ch_cnt  <= '0;
          r_pix_cnt <= w_pix_last ? '0 : r_pix_cnt + PIX_W'(1);
        end else begin
          r_ch_cnt <= r_ch_cnt + CH_W'(1);
        end
      end
    end
  end

  assign o_valid_out  = r_valid_out;
  assign o_frame_done = r_frame_done;
  assign o_align_err  = r_align_err;

endmodule

`default_nettype wire

// File: rtl/split_32o.sv
// Deserializes a channel-interleaved pixel stream into CH parallel lanes.
`default_nettype none

module split_32o
  import split_32o_pkg::*;
#(
  parameter int D          = DEF_D,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CH         = DEF_CH
) (
  input  wire logic  clk,
  input  wire logic  reset,
  split_32o_if.slave bus
);

  localparam int CH_W = idx_width(CH);

  logic [DATA_WIDTH-1:0]    r_shadow [0:CH-2];
  logic [CH*DATA_WIDTH-1:0] r_pxl_out;
  logic [CH*DATA_WIDTH-1:0] w_group;

  logic            w_wr_en;
  logic [CH_W-1:0] w_wr_idx;
  logic            w_emit;
  logic            w_valid_out;
  logic            w_frame_done;
  logic            w_align_err;

  split_pos_counter #(
    .D    (D),
    .CH   (CH),
    .CH_W (CH_W)
  ) u_pos (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (bus.valid_in),
    .i_sof        (bus.sof_in),
    .o_wr_en      (w_wr_en),
    .o_wr_idx     (w_wr_idx),
    .o_emit       (w_emit),
    .o_valid_out  (w_valid_out),
    .o_frame_done (w_frame_done),
    .o_align_err  (w_align_err)
  );

  // Shadow slots refill while pxl_out still presents the previous group.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CH - 1; k++) begin
      if (w_wr_en && (w_wr_idx == CH_W'(k)))
        r_shadow[k] <= bus.pxl_in;
    end
  end

  for (genvar k = 0; k < CH - 1; k++) begin : g_lane
    assign w_group[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH] = r_shadow[k];
  end
  assign w_group[lane_lo(CH - 1, DATA_WIDTH) +: DATA_WIDTH] = bus.pxl_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_pxl_out <= '0;
    else if (w_emit)
      r_pxl_out <= w_group;
  end

  assign bus.pxl_out    = r_pxl_out;
  assign bus.valid_out  = w_valid_out;
  assign bus.frame_done = w_frame_done;
  assign bus.align_err  = w_align_err;

endmodule

`default_nettype wire

// File: tb/tb_split_32o.sv
// Randomized and directed checks of split_32o against a queue-based stream model.
`default_nettype none

module tb_split_32o;

  localparam int D  = 2;
  localparam int DW = 32;
  localparam int CH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  split_32o_if #(.DATA_WIDTH(DW), .CH(CH)) bus ();

  split_32o #(.D(D), .DATA_WIDTH(DW), .CH(CH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: collected words of the current group, emitted group count.
  logic [DW-1:0]    m_q [$];
  int               m_pix;
  bit               m_err;
  bit               m_v;
  bit               m_fd;
  logic [CH*DW-1:0] m_pxl;
  int               v_seen;
  int               fd_seen;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_pix = 0;
    m_err = 1'b0;
    m_v   = 1'b0;
    m_fd  = 1'b0;
    m_pxl = '0;
  endtask

  task automatic model_step();
    m_v  = 1'b0;
    m_fd = 1'b0;
    if (bus.valid_in) begin
      if (bus.sof_in) begin
        if (m_q.size() != 0 || m_pix != 0) m_err = 1'b1;
        m_q.delete();
        m_q.push_back(bus.pxl_in);
        m_pix = 0;
      end else begin
        m_q.push_back(bus.pxl_in);
        if (m_q.size() == CH) begin
          for (int k = 0; k < CH; k++) m_pxl[k*DW +: DW] = m_q[k];
          m_v   = 1'b1;
          m_fd  = (m_pix == D * D - 1);
          m_pix = (m_pix + 1) % (D * D);
          m_q.delete();
        end
      end
    end
  endtask

  task automatic check_outputs();
    v_seen  += int'(bus.valid_out);
    fd_seen += int'(bus.frame_done);
    check("valid_out",  {31'd0, bus.valid_out},  {31'd0, m_v});
    check("frame_done", {31'd0, bus.frame_done}, {31'd0, m_fd});
    check("align_err",  {31'd0, bus.align_err},  {31'd0, m_err});
    for (int k = 0; k < CH; k++)
      check($sformatf("pxl_lane%0d", k), bus.pxl_out[k*DW +: DW], m_pxl[k*DW +: DW]);
  endtask

  task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
    @(negedge clk);
    bus.valid_in = v;
    bus.sof_in   = s;
    bus.pxl_in   = d;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), $urandom);
  endtask

  // Asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.sof_in   = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_outputs();
    idle(2);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.sof_in   = 1'b0;
    bus.pxl_in   = '0;
    reset        = 1'b0;
    v_seen       = 0;
    fd_seen      = 0;
    model_clear();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b1;
    idle(3);

    // Contiguous group
    for (int k = 0; k < CH; k++) step(1'b1, k == 0, DW'(k + 1));
    check("contig_valid", {31'd0, bus.valid_out}, 32'd1);
    check("contig_lane0", bus.pxl_out[0 +: DW], 32'd1);
    check("contig_lane31", bus.pxl_out[31*DW +: DW], 32'd32);
    idle(3);

    // Gapped group, then hold
    for (int k = 0; k < CH; k++) begin
      step(1'b1, 1'b0, DW'(k + 1));
      if (k == CH - 1) check("gap_valid", {31'd0, bus.valid_out}, 32'd1);
      step(1'b0, 1'b0, $urandom);
    end
    idle(5);
    check("gap_hold_lane17", bus.pxl_out[17*DW +: DW], 32'd18);

    // Full frame plus one extra group
    async_reset();
    v_seen  = 0;
    fd_seen = 0;
    for (int n = 0; n < 4 * CH; n++) step(1'b1, n == 0, DW'(32'h100 + n));
    check("frame_pulses", v_seen, 32'd4);
    check("frame_done_cnt", fd_seen, 32'd1);
    for (int n = 0; n < CH; n++) step(1'b1, 1'b0, DW'(32'h200 + n));
    check("frame5_pulses", v_seen, 32'd5);
    check("frame5_done_cnt", fd_seen, 32'd1);

    // Misalignment: sof mid-group
    async_reset();
    v_seen = 0;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, $urandom);
    check("mis_no_valid", v_seen, 32'd0);
    for (int k = 0; k < CH; k++) step(1'b1, k == 0, DW'(32'h500 + k));
    check("mis_err", {31'd0, bus.align_err}, 32'd1);
    check("mis_pulses", v_seen, 32'd1);
    check("mis_lane9", bus.pxl_out[9*DW +: DW], 32'h509);
    idle(4);
    check("mis_sticky", {31'd0, bus.align_err}, 32'd1);

    // Reset mid-group, then a clean group without sof
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, $urandom);
    async_reset();
    for (int k = 0; k < CH; k++) step(1'b1, 1'b0, DW'(32'h700 + k));
    check("rst_clean_err", {31'd0, bus.align_err}, 32'd0);
    check("rst_lane0", bus.pxl_out[0 +: DW], 32'h700);

    // Random traffic with occasional stray sof
    async_reset();
    for (int i = 0; i < 2000; i++) begin
      bit v;
      bit s;
      v = ($urandom_range(3, 0) != 0);
      s = ($urandom_range(199, 0) == 0);
      step(v, s, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/split_32o.md
Name: split_32o

Overview:
- Inverse of the channel-merge stage: deserializes one channel-interleaved pixel stream into CH parallel channel lanes.
- Input order per spatial pixel is ch0, ch1, ..., ch(CH-1).
- Feeds per-channel convolution/pooling stages that need all channels of one pixel together.
- Also tracks the pixel position inside a D x D feature map and flags stream misalignment.

Parameters:
- D, 110: feature-map width. A frame is D*D pixel groups.
- DATA_WIDTH, 32: width of one channel word.
- CH, 32: number of channels per pixel group. Must be >= 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  pxl_in carries a valid channel word this cycle.
- sof_in  in  1  start-of-frame; qualified by valid_in; marks ch0 of pixel 0.
- pxl_in  in  DATA_WIDTH  serial channel word.
- pxl_out  out  CH*DATA_WIDTH  parallel group; channel k at pxl_out[k*DATA_WIDTH +: DATA_WIDTH], ch0 at the LSBs.
- valid_out  out  1  one-cycle pulse when pxl_out is updated with a complete group.
- frame_done  out  1  one-cycle pulse, coincident with valid_out of group D*D-1.
- align_err  out  1  sticky misalignment flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - pxl_out, valid_out, frame_done, align_err = 0.
  - ch_cnt and pix_cnt = 0.
  - Shadow buffer contents are don't-care.
- Counter widths:
  - ch_cnt is $clog2(CH) bits.
  - pix_cnt is $clog2(D*D) bits.
  - No arithmetic on data; words are passed through bit-exact.
- Accept rule: a word is accepted on any cycle with valid_in=1. There is no backpressure; the block must accept one word every cycle.
- On an accepted word with ch_cnt < CH-1:
  - Store it in shadow slot ch_cnt.
  - ch_cnt increments.
- On an accepted word with ch_cnt == CH-1:
  - On the next edge, pxl_out loads {pxl_in, shadow[CH-2:0]} and valid_out=1.
  - ch_cnt wraps to 0.
  - Latency: 1 cycle from the last channel word to valid_out.
- Output hold: pxl_out holds its value between groups. valid_out is high for exactly one cycle per group.
- Back-to-back groups: valid_out may pulse every CH cycles.
  - The shadow slots refill while pxl_out holds the previous group.
  - No second output register is required.
- Gaps (valid_in=0): all state holds. Gaps anywhere in a group must not change the result.
- pix_cnt:
  - Increments on each group emission.
  - When it is D*D-1 at emission, frame_done=1 with that valid_out and pix_cnt wraps to 0.
- sof_in=1 with valid_in=1:
  - The word is forced into ch0 (ch_cnt becomes 1) and pix_cnt is set to 0.
  - If ch_cnt != 0 or pix_cnt != 0 before this word, align_err is set and stays 1 until reset.
  - Any partially collected group is discarded; no valid_out is produced for it.
- sof_in=1 with valid_in=0: ignored.
- sof_in on the ch_cnt == CH-1 slot:
  - The sof rule takes priority: no emission, align_err=1, the word becomes ch0.
  - This applies for any CH >= 2.
- Reset mid-group or mid-frame: all state is cleared. The first word after release is ch0 of pixel 0, regardless of sof_in.

Decomposition:
- Shared package (cnn_stream_pkg):
  - DATA_WIDTH and CH defaults.
  - Channel-index width function (clog2).
  - Lane slicing macro/function for packed CH*DATA_WIDTH buses, reused by merge_32i and the adders.
- One natural sub-module: split_pos_counter.
  - Contains ch_cnt, pix_cnt, the sof/alignment logic, and the emit/frame_done strobes.
- The top level holds the shadow buffer and the pxl_out register.

Test Plan (bench parameters CH=32, D=2, DATA_WIDTH=32):
- Reset: assert reset=0 mid-cycle → all outputs 0 immediately; release → still 0 with valid_in=0.
- Contiguous group: 32 words with value k+1 for k=0..31, sof on the first → valid_out one cycle after word 32; lane k = k+1; frame_done=0; align_err=0.
- Gapped input: same 32 words with valid_in alternating 1/0 → identical pxl_out; valid_out exactly one cycle after the last accepted word; pxl_out stable until the next group.
- Frame: 4 back-to-back groups (128 words, values 0x100+n) → 4 valid_out pulses 32 cycles apart; frame_done only with the 4th; a 5th group gives frame_done=0.
- Misalignment: sof_in after 10 words of a group → align_err=1 (sticky); no valid_out for the 10 words; the following 32 words from the sof word emit correctly.
- Reset mid-operation: reset after 16 words → outputs cleared; the next 32 words (no sof) produce a clean group with align_err=0.
